mul_div_seq: RTL

- Multi-cycle sequencer for MULT/MULTU/DIV/DIVU that owns the HI/LO register pair.
- Performs the 32 add/subtract steps of shift-add multiply and restoring divide on the shared 32-bit ALU. It drives that ALU through its alu* ports: ADDU for multiply, SUBU for divide.
- Sits beside the execute stage. The core stalls on busy and reads hi/lo for MFHI/MFLO.

---
 rtl/mul_div_seq.sv | 214 +++++++++++++++++++++
 1 files changed

// File: rtl/mul_div_seq.sv
// mul_div_seq: multi-cycle MULT/MULTU/DIV/DIVU sequencer that owns HI/LO.
// It runs 32 shift-add (multiply) or restoring-subtract (divide) steps on the
// shared ALU, which is driven through the alu* ports.
module mul_div_seq #(
  parameter int ITERS = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] opA,
  input  logic [31:0] opB,
  input  logic        abort,
  input  logic        hiWe,
  input  logic        loWe,
  input  logic [31:0] wdata,
  output logic [31:0] aluOpA,
  output logic [31:0] aluOpB,
  output logic [5:0]  aluFunct,
  input  logic [31:0] aluOut,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  // ALU function codes (MIPS SPECIAL funct field values).
  localparam logic [5:0] FUN_ADDU = 6'h21;
  localparam logic [5:0] FUN_SUBU = 6'h23;
  localparam logic [5:0] FUN_NO   = 6'h00;
  localparam logic [4:0] CNT_LAST = 5'(ITERS - 1);

  typedef enum logic [1:0] {S_IDLE, S_ABS, S_ITER, S_FIX} state_t;

  state_t      state_q, state_d;
  logic        is_div_q, is_div_d;   // op[1]: divide family
  logic        sa_q, sa_d;           // operand A negative and op is signed
  logic        sb_q, sb_d;           // operand B negative and op is signed
  logic        dz_q, dz_d;           // divide by zero
  logic [31:0] a_q, a_d;             // raw latched opA (needed for div-by-zero hi)
  logic [31:0] b_q, b_d;             // opB, magnitude after ABS (mcand / divisor)
  logic [31:0] acc_q, acc_d;         // product high half / partial remainder
  logic [31:0] sr_q, sr_d;           // multiplier / quotient shift register
  logic [4:0]  cnt_q, cnt_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic        done_q, done_d;

  logic [31:0] sum;
  logic        carry;
  logic [32:0] rem33;
  logic [63:0] prod;

  function automatic logic [31:0] neg32(input logic [31:0] x);
    return (~x) + 32'd1;
  endfunction

  function automatic logic [63:0] neg64(input logic [63:0] x);
    return (~x) + 64'd1;
  endfunction

  function automatic logic [31:0] mag32(input logic [31:0] x, input logic neg);
    return neg ? neg32(x) : x;
  endfunction

  // State register and datapath registers; everything clears on reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      is_div_q <= 1'b0;
      sa_q     <= 1'b0;
      sb_q     <= 1'b0;
      dz_q     <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      acc_q    <= '0;
      sr_q     <= '0;
      cnt_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      is_div_q <= is_div_d;
      sa_q     <= sa_d;
      sb_q     <= sb_d;
      dz_q     <= dz_d;
      a_q      <= a_d;
      b_q      <= b_d;
      acc_q    <= acc_d;
      sr_q     <= sr_d;
      cnt_q    <= cnt_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      done_q   <= done_d;
    end
  end

  // Next-state, iteration datapath, ALU drive and HI/LO update.
  always_comb begin
    state_d  = state_q;
    is_div_d = is_div_q;
    sa_d     = sa_q;
    sb_d     = sb_q;
    dz_d     = dz_q;
    a_d      = a_q;
    b_d      = b_q;
    acc_d    = acc_q;
    sr_d     = sr_q;
    cnt_d    = cnt_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    done_d   = 1'b0;
    aluOpA   = '0;
    aluOpB   = '0;
    aluFunct = FUN_NO;
    sum      = '0;
    carry    = 1'b0;
    rem33    = '0;
    prod     = '0;

    unique case (state_q)
      S_IDLE: begin
        // MTHI/MTLO only land while idle; a start in the same cycle still
        // launches and its result overwrites these later.
        if (hiWe) hi_d = wdata;
        if (loWe) lo_d = wdata;
        if (start && !abort) begin
          state_d  = S_ABS;
          is_div_d = op[1];
          sa_d     = opA[31] & ~op[0];
          sb_d     = opB[31] & ~op[0];
          dz_d     = op[1] & (opB == 32'd0);
          a_d      = opA;
          b_d      = opB;
        end
      end

      S_ABS: begin
        acc_d   = '0;
        sr_d    = mag32(a_q, sa_q);
        b_d     = mag32(b_q, sb_q);
        cnt_d   = '0;
        state_d = S_ITER;
      end

      S_ITER: begin
        if (!is_div_q) begin
          aluOpA   = acc_q;
          aluOpB   = b_q;
          aluFunct = FUN_ADDU;
          if (sr_q[0]) begin
            sum   = aluOut;
            carry = (aluOut < acc_q);
          end else begin
            sum   = acc_q;
            carry = 1'b0;
          end
          acc_d = {carry, sum[31:1]};
          sr_d  = {sum[0], sr_q[31:1]};
        end else begin
          // rem33[32] set means the shifted remainder already exceeds any
          // 32-bit divisor; the wrapped ALU difference is still exact.
          rem33    = {acc_q, sr_q[31]};
          aluOpA   = rem33[31:0];
          aluOpB   = b_q;
          aluFunct = FUN_SUBU;
          if (rem33[32] || (rem33[31:0] >= b_q)) begin
            acc_d = aluOut;
            sr_d  = {sr_q[30:0], 1'b1};
          end else begin
            acc_d = rem33[31:0];
            sr_d  = {sr_q[30:0], 1'b0};
          end
        end
        if (cnt_q == CNT_LAST) state_d = S_FIX;
        else                   cnt_d   = cnt_q + 5'd1;
      end

      S_FIX: begin
        if (!is_div_q) begin
          prod = {acc_q, sr_q};
          if (sa_q ^ sb_q) prod = neg64(prod);
          hi_d = prod[63:32];
          lo_d = prod[31:0];
        end else if (dz_q) begin
          lo_d = 32'hFFFF_FFFF;
          hi_d = a_q;
        end else begin
          lo_d = (sa_q ^ sb_q) ? neg32(sr_q) : sr_q;
          hi_d = sa_q ? neg32(acc_q) : acc_q;
        end
        done_d  = 1'b1;
        state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase

    // Flush: drop the in-flight operation without touching HI/LO.
    if (abort && (state_q != S_IDLE)) begin
      state_d = S_IDLE;
      hi_d    = hi_q;
      lo_d    = lo_q;
      done_d  = 1'b0;
    end
  end

  assign busy = (state_q != S_IDLE);
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule
